// File: rtl/boxcar_decimator_if.sv
// boxcar_decimator_if: sample-stream and decimated-output bundle for the
// boxcar decimator.
//
// Parameters:
//   IN_WIDTH  - input sample width (unsigned)
//   L2_DECIM  - log2 of the decimation factor
// Signals:
//   in_valid  - qualifies in_data this cycle            (master -> slave)
//   in_data   - unsigned input sample, IN_WIDTH bits     (master -> slave)
//   sync      - window restart, only with BOXCAR_SYNC_EN (master -> slave)
//   out_data  - last completed window sum, OUT_WIDTH bits (slave -> master)
//   out_stb   - one-cycle pulse marking a new out_data   (slave -> master)
// Optional feature macro: BOXCAR_SYNC_EN (adds the sync signal).
interface boxcar_decimator_if #(
    parameter int IN_WIDTH = 26,
    parameter int L2_DECIM = 4
);
    localparam int OUT_WIDTH = IN_WIDTH + L2_DECIM;

    logic                 in_valid;
    logic [IN_WIDTH-1:0]  in_data;
`ifdef BOXCAR_SYNC_EN
    logic                 sync;
`endif
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_stb;

`ifdef BOXCAR_SYNC_EN
    modport master (output in_valid, in_data, sync, input  out_data, out_stb);
    modport slave  (input  in_valid, in_data, sync, output out_data, out_stb);
`else
    modport master (output in_valid, in_data, input  out_data, out_stb);
    modport slave  (input  in_valid, in_data, output out_data, out_stb);
`endif
endinterface

// File: rtl/boxcar_decimator.sv
// boxcar_decimator: sums each non-overlapping window of 2^L2_DECIM valid
// samples and emits the full-precision sum with a one-cycle strobe.
//
// Parameters:
//   IN_WIDTH  - input sample width (unsigned), default 26
//   L2_DECIM  - log2 of decimation factor N, legal 0..8, default 4
//   OUT_WIDTH - derived localparam, IN_WIDTH + L2_DECIM
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - boxcar_decimator_if.slave: in_valid, in_data, [sync],
//         out_data (registered window sum), out_stb (one-cycle pulse)
// Optional feature macro: BOXCAR_SYNC_EN adds the sync window-restart input.
module boxcar_decimator #(
    parameter int IN_WIDTH = 26,
    parameter int L2_DECIM = 4
) (
    input logic               clk,
    input logic               rst,
    boxcar_decimator_if.slave bus
);
    localparam int OUT_WIDTH = IN_WIDTH + L2_DECIM;
    // With L2_DECIM=0 the counter is a single bit that stays at zero.
    localparam int CNT_W = (L2_DECIM == 0) ? 1 : L2_DECIM;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << L2_DECIM) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stb_q, stb_d;

    logic [OUT_WIDTH-1:0] in_ext_w;
    logic [OUT_WIDTH-1:0] sum_w;
    logic                 last_w;

    assign in_ext_w = OUT_WIDTH'(bus.in_data);
    // N samples of (2^IN_WIDTH-1) fit exactly in OUT_WIDTH, so no carry out.
    assign sum_w    = acc_q + in_ext_w;
    // For N=1 CNT_LAST is zero and cnt never leaves zero: every sample closes a window.
    assign last_w   = (cnt_q == CNT_LAST);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_d = out_q;
        stb_d = 1'b0;
`ifdef BOXCAR_SYNC_EN
        // sync outranks window completion: the partial window is dropped and
        // the current sample (if any) opens a fresh window.
        if (bus.sync) begin
            acc_d = '0;
            cnt_d = '0;
            if (bus.in_valid) begin
                if (L2_DECIM == 0) begin
                    out_d = in_ext_w;
                    stb_d = 1'b1;
                end else begin
                    acc_d = in_ext_w;
                    cnt_d = CNT_ONE;
                end
            end
        end else
`endif
        if (bus.in_valid) begin
            if (last_w) begin
                out_d = sum_w;
                stb_d = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_w;
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            stb_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            stb_q <= stb_d;
        end
    end

    assign bus.out_data = out_q;
    assign bus.out_stb  = stb_q;
endmodule

// File: tb/tb_boxcar_decimator.sv
// tb_boxcar_decimator: three decimator lanes checked against a queue-based
// window model.
//   lane0: IN_WIDTH=8,  L2_DECIM=2
//   lane1: IN_WIDTH=26, L2_DECIM=4 (defaults)
//   lane2: IN_WIDTH=8,  L2_DECIM=0
// Honours BOXCAR_SYNC_EN (drives sync when defined).
module tb_boxcar_decimator;
    localparam int NI = 3;

    typedef struct {
        string  nm;
        int     lane;
        int     kind;   // 0: out_stb, 1: out_data, 2: strobe count
        longint val;
    } pin_t;

    logic        clk;
    logic        rst;
    logic        v  [NI];
    logic [25:0] d  [NI];
`ifdef BOXCAR_SYNC_EN
    logic        sync_s;
`endif

    logic        os [NI];
    logic [29:0] od [NI];
    logic        es [NI];
    logic [29:0] ed [NI];

    int     total;
    int     bad;
    int     stb_cnt [NI];
    pin_t   pins [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_lane
        localparam int IW = (g == 1) ? 26 : 8;
        localparam int L2 = (g == 0) ? 2 : ((g == 1) ? 4 : 0);
        localparam int OW = IW + L2;
        localparam int N  = 1 << L2;

        boxcar_decimator_if #(.IN_WIDTH(IW), .L2_DECIM(L2)) bus ();

        assign bus.in_valid = v[g];
        assign bus.in_data  = d[g][IW-1:0];
`ifdef BOXCAR_SYNC_EN
        assign bus.sync     = sync_s;
`endif

        boxcar_decimator #(.IN_WIDTH(IW), .L2_DECIM(L2)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Model: collect valid samples of the open window; once N are held,
        // their sum is the next output.
        longint          win [$];
        logic [OW-1:0]   exp_data;
        logic            exp_stb;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                win.delete();
                exp_data <= '0;
                exp_stb  <= 1'b0;
            end else begin
                exp_stb <= 1'b0;
`ifdef BOXCAR_SYNC_EN
                if (bus.sync) begin
                    win.delete();
                    if (bus.in_valid) begin
                        if (N == 1) begin
                            exp_data <= OW'(bus.in_data);
                            exp_stb  <= 1'b1;
                        end else begin
                            win.push_back(longint'(bus.in_data));
                        end
                    end
                end else
`endif
                if (bus.in_valid) begin
                    win.push_back(longint'(bus.in_data));
                    if (win.size() == N) begin
                        exp_data <= OW'(win.sum());
                        exp_stb  <= 1'b1;
                        win.delete();
                    end
                end
            end
        end

        assign os[g] = bus.out_stb;
        assign od[g] = 30'(bus.out_data);
        assign es[g] = exp_stb;
        assign ed[g] = 30'(exp_data);
    end

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: model vs DUT every cycle, plus literal pins.
    always @(negedge clk) begin
        pin_t p;
        for (int i = 0; i < NI; i++) begin
            if (os[i] === 1'b1) stb_cnt[i]++;
            check($sformatf("lane%0d_stb", i),  longint'(os[i]), longint'(es[i]));
            check($sformatf("lane%0d_data", i), longint'(od[i]), longint'(ed[i]));
        end
        while (pins.size() > 0) begin
            p = pins.pop_front();
            case (p.kind)
                0:       check(p.nm, longint'(os[p.lane]), p.val);
                1:       check(p.nm, longint'(od[p.lane]), p.val);
                default: check(p.nm, longint'(stb_cnt[p.lane]), p.val);
            endcase
        end
    end

    task automatic pin(input string nm, input int lane, input int kind, input longint val);
        pin_t p;
        p.nm = nm; p.lane = lane; p.kind = kind; p.val = val;
        pins.push_back(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) v[i] = 1'b0;
    endtask

    initial begin
        int l2v [3];
        int base;
        l2v[0] = 3; l2v[1] = 0; l2v[2] = 255;
        total = 0;
        bad   = 0;
        for (int i = 0; i < NI; i++) begin
            v[i] = 1'b0; d[i] = '0; stb_cnt[i] = 0;
        end
`ifdef BOXCAR_SYNC_EN
        sync_s = 1'b0;
`endif
        rst = 1'b0;
        #1 rst = 1'b1;
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            pin("reset_stb", i, 0, 0);
            pin("reset_data", i, 1, 0);
        end
        rst = 1'b0;
        step();

        // Lane0: continuous 1..8; lane2: 3,0,255 forwarded.
        for (int k = 1; k <= 8; k++) begin
            v[0] = 1'b1; d[0] = 26'(k);
            if (k <= 3) begin v[2] = 1'b1; d[2] = 26'(l2v[k-1]); end
            else v[2] = 1'b0;
            step();
            if (k == 3) pin("l0_no_early_stb", 0, 0, 0);
            if (k == 4) begin pin("l0_win1_stb", 0, 0, 1); pin("l0_win1_data", 0, 1, 10); end
            if (k == 5) begin pin("l0_stb_single", 0, 0, 0); pin("l0_hold", 0, 1, 10); end
            if (k == 8) begin pin("l0_win2_stb", 0, 0, 1); pin("l0_win2_data", 0, 1, 26); end
            if (k <= 3) begin
                pin("l2_fwd_stb", 2, 0, 1);
                pin("l2_fwd_data", 2, 1, longint'(l2v[k-1]));
            end
        end
        idle_all();
        step();
        pin("l0_after_stb", 0, 0, 0);
        pin("l0_after_data", 0, 1, 26);

        // Lane0: 10,20,30,40 with three idle cycles between.
        base = stb_cnt[0];
        for (int k = 0; k < 4; k++) begin
            v[0] = 1'b1; d[0] = 26'(10 * (k + 1));
            step();
            idle_all();
            if (k < 3) repeat (3) step();
        end
        pin("l0_gap_stb", 0, 0, 1);
        pin("l0_gap_data", 0, 1, 100);
        step();
        pin("l0_gap_count", 0, 2, longint'(base + 1));

        // Lane1: full-scale window then a zero window.
        for (int k = 0; k < 32; k++) begin
            v[1] = 1'b1; d[1] = (k < 16) ? 26'h3FFFFFF : 26'h0;
            step();
            if (k == 15) begin pin("l1_max_stb", 1, 0, 1); pin("l1_max_data", 1, 1, 64'h3FFFFFF0); end
            if (k == 31) begin pin("l1_zero_stb", 1, 0, 1); pin("l1_zero_data", 1, 1, 0); end
        end
        idle_all();
        step();

        // Lane0: partial window discarded by reset.
        for (int k = 0; k < 2; k++) begin
            v[0] = 1'b1; d[0] = 26'd5;
            step();
        end
        idle_all();
        rst = 1'b1;
        pin("l0_rst_data", 0, 1, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v[0] = 1'b1; d[0] = 26'd1;
            step();
        end
        idle_all();
        pin("l0_post_rst_stb", 0, 0, 1);
        pin("l0_post_rst_data", 0, 1, 4);
        step();

`ifdef BOXCAR_SYNC_EN
        // Lane0: 9,9,9 then 7 with sync, then 1,1,1.
        for (int k = 0; k < 7; k++) begin
            v[0] = 1'b1;
            d[0] = (k < 3) ? 26'd9 : ((k == 3) ? 26'd7 : 26'd1);
            sync_s = (k == 3);
            step();
            if (k == 3) begin pin("l0_sync_no_stb", 0, 0, 0); pin("l0_sync_hold", 0, 1, 4); end
        end
        sync_s = 1'b0;
        idle_all();
        pin("l0_sync_stb", 0, 0, 1);
        pin("l0_sync_data", 0, 1, 10);
        step();
`endif

        // Randomized traffic on all lanes.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 600) == 0) begin
                idle_all();
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    v[i] = ($urandom_range(0, 9) < 7);
                    d[i] = ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : 26'($urandom);
                end
`ifdef BOXCAR_SYNC_EN
                sync_s = ($urandom_range(0, 30) == 0);
`endif
                step();
            end
        end
        idle_all();
`ifdef BOXCAR_SYNC_EN
        sync_s = 1'b0;
`endif
        step();
        step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
